// File: rtl/rf_pkg.sv
// Shared types and default sizes for the register-file burst reader.
// Holds the FSM state encoding and the reg_flat word-slicing helper.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NREG   = 1 << RF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } rf_state_e;

  // Register idx of a flattened default-sized register file.
  function automatic logic [RF_DATA_W-1:0] rf_word(
    input logic [RF_NREG*RF_DATA_W-1:0] flat,
    input logic [RF_ADDR_W-1:0]         idx
  );
    return flat[int'(idx)*RF_DATA_W +: RF_DATA_W];
  endfunction

endpackage

// File: rtl/rf_read_mux.sv
// Combinational NREG:1 word select out of the flattened register file.
module rf_read_mux
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic [(2**ADDR_W)*DATA_W-1:0] reg_flat,
  input  logic [ADDR_W-1:0]             sel,
  output logic [DATA_W-1:0]             word
);

  localparam int NREG = 2 ** ADDR_W;

  always_comb begin
    word = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel == ADDR_W'(i)) word = reg_flat[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/rf_burst_read.sv
// Burst read engine: streams consecutive registers out on a registered valid/ready port.
// Optional write-through forwarding of a same-cycle write is enabled by RF_WR_BYPASS_EN.
module rf_burst_read
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             start_addr,
  input  logic [LEN_W-1:0]              burst_len,
  input  logic [(2**ADDR_W)*DATA_W-1:0] reg_flat,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             wAddr,
  input  logic [DATA_W-1:0]             wData,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DATA_W-1:0]             rd_data,
  output logic [ADDR_W-1:0]             rd_addr,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    state_dbg
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [LEN_W-1:0] NREG_L = LEN_W'(NREG);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_READ = READ;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]        state;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_c;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] mux_word;
  logic [DATA_W-1:0] load_data;

  // Handshake: a beat moves on any rising edge with rd_valid && rd_ready; while
  // rd_valid is high and rd_ready low, rd_data/rd_addr are held unchanged.

  assign len_c     = (burst_len > NREG_L) ? NREG_L : burst_len;
  assign load_addr = (state == ST_IDLE) ? start_addr : rd_addr + ADDR_W'(1);

  rf_read_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mux (
    .reg_flat (reg_flat),
    .sel      (load_addr),
    .word     (mux_word)
  );

`ifdef RF_WR_BYPASS_EN
  assign load_data = (we && (wAddr == load_addr)) ? wData : mux_word;
`else
  // Write port is inert in this build; same-cycle writes return the old value.
  logic unused_bypass;
  assign unused_bypass = ^{we, wAddr, wData};
  assign load_data     = mux_word;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_addr   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len_c != '0) begin
              state     <= ST_READ;
              rd_valid  <= 1'b1;
              rd_addr   <= load_addr;
              rd_data   <= load_data;
              remaining <= len_c - LEN_W'(1);
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_READ: begin
          if (rd_valid && rd_ready) begin
            if (remaining != '0) begin
              rd_addr   <= load_addr;
              rd_data   <= load_data;
              remaining <= remaining - LEN_W'(1);
            end else begin
              rd_valid <= 1'b0;
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_rf_burst_read.sv
// Directed bench for rf_burst_read: beats are checked against an expected queue.
// Build with +define+RF_WR_BYPASS_EN to exercise the forwarding build.
module tb_rf_burst_read;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int LW = AW + 1;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] burst_len;
  logic [NR*DW-1:0] reg_flat;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  logic [DW-1:0] regs [NR];
  logic [AW+DW-1:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  // clock / reset
  always #5 clk = ~clk;

  rf_burst_read dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .reg_flat   (reg_flat),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_addr    (rd_addr),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int idx, input logic [DW-1:0] val);
    regs[idx] = val;
    reg_flat[idx*DW +: DW] = val;
  endtask

  task automatic push_burst(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] p;
    p = a;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({p, regs[p]});
      p = p + AW'(1);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && !done; i++) step();
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
    step();
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard: sample the beat on the falling edge ahead of its transfer edge
  always @(negedge clk) begin
    if (reset_n && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_beat observed=%h expected=none", {rd_addr, rd_data});
      end else begin
        check("beat", 64'({rd_addr, rd_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [DW-1:0] held;
    reset_n = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0;
    we = 1'b0; wAddr = '0; wData = '0; rd_ready = 1'b1; reg_flat = '0;
    for (int i = 0; i < NR; i++) set_reg(i, 32'h1000_0000 + DW'(i));
    step(); step();
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_addr", 64'(rd_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    reset_n = 1'b1;
    step();

    // basic burst 2,3,4 with latency 1 and done right after the last beat
    start = 1'b1; start_addr = 3'd2; burst_len = 4'd3;
    push_burst(3'd2, 3);
    step(); start = 1'b0;
    check("basic_first_valid", 64'(rd_valid), 64'd1);
    check("basic_first_addr", 64'(rd_addr), 64'd2);
    step(); step(); step();
    check("basic_done_timing", 64'(done), 64'd1);
    check("basic_valid_clear", 64'(rd_valid), 64'd0);
    step();
    check("basic_done_pulse", 64'(done), 64'd0);

    // wrap-around 6,7,0,1
    start = 1'b1; start_addr = 3'd6; burst_len = 4'd4;
    push_burst(3'd6, 4);
    step(); start = 1'b0;
    check("wrap_busy", 64'(busy), 64'd1);
    wait_done("wrap");

    // backpressure on beat 0 while reg[3] changes
    rd_ready = 1'b0; start = 1'b1; start_addr = 3'd3; burst_len = 4'd2;
    held = regs[3];
    push_burst(3'd3, 2);
    step(); start = 1'b0;
    set_reg(3, 32'hCAFE_0003);
    for (int i = 0; i < 3; i++) begin
      check("stall_data", 64'(rd_data), 64'(held));
      check("stall_addr", 64'(rd_addr), 64'd3);
      step();
    end
    rd_ready = 1'b1;
    step();
    check("bp_second_addr", 64'(rd_addr), 64'd4);
    check("bp_second_valid", 64'(rd_valid), 64'd1);
    wait_done("bp");
    set_reg(3, 32'h1000_0003);

    // zero length: no beat, done one cycle later
    start = 1'b1; start_addr = 3'd1; burst_len = 4'd0;
    step(); start = 1'b0;
    check("zero_valid", 64'(rd_valid), 64'd0);
    check("zero_done", 64'(done), 64'd1);
    step();
    check("zero_idle", 64'(busy), 64'd0);

    // start during a burst is ignored
    start = 1'b1; start_addr = 3'd0; burst_len = 4'd3;
    push_burst(3'd0, 3);
    step(); start = 1'b0;
    step();
    start = 1'b1; start_addr = 3'd5; burst_len = 4'd5;
    step(); start = 1'b0;
    wait_done("ignored_start");

    // oversize length clamps to NREG beats
    start = 1'b1; start_addr = 3'd1; burst_len = 4'd12;
    push_burst(3'd1, NR);
    step(); start = 1'b0;
    wait_done("clamp");

    // same-cycle write on the load of register 5
    start = 1'b1; start_addr = 3'd5; burst_len = 4'd1;
    we = 1'b1; wAddr = 3'd5; wData = 32'hDEAD_BEEF;
`ifdef RF_WR_BYPASS_EN
    exp_q.push_back({3'd5, 32'hDEAD_BEEF});
`else
    exp_q.push_back({3'd5, regs[5]});
`endif
    step(); start = 1'b0; we = 1'b0;
    wait_done("bypass");

    // write to another address never forwards
    start = 1'b1; start_addr = 3'd5; burst_len = 4'd1;
    we = 1'b1; wAddr = 3'd6; wData = 32'h0BAD_F00D;
    push_burst(3'd5, 1);
    step(); start = 1'b0; we = 1'b0;
    wait_done("bypass_miss");

    // reset on beat 2 of 5, then a full burst after release
    start = 1'b1; start_addr = 3'd0; burst_len = 4'd5;
    push_burst(3'd0, 5);
    step(); start = 1'b0;
    step(); step();
    check("pre_rst_addr", 64'(rd_addr), 64'd2);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_data", 64'(rd_data), 64'd0);
    check("mid_rst_addr", 64'(rd_addr), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    step();
    check("mid_rst_done_held", 64'(done), 64'd0);
    reset_n = 1'b1;
    step();
    check("post_rst_done", 64'(done), 64'd0);
    start = 1'b1; start_addr = 3'd3; burst_len = 4'd5;
    push_burst(3'd3, 5);
    step(); start = 1'b0;
    wait_done("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_burst_read.md
Name: rf_burst_read

Overview:
Read-side engine for the 8-entry register file, the counterpart of the decoder-driven write-enable path. It takes a start address and a beat count, then reads consecutive registers. Each word is presented on a registered valid/ready stream toward the consumer (ALU operand latch / debug dump). It sits beside the register array and samples its flattened contents.

Parameters:
DATA_W, 32, width of one register
ADDR_W, 3, register address width; register count NREG = 2**ADDR_W
LEN_W, ADDR_W+1, burst-length width; allows 0..NREG beats

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  burst request; sampled only in IDLE
start_addr  input  ADDR_W  first register of burst
burst_len  input  LEN_W  number of beats, 0..NREG
reg_flat  input  NREG*DATA_W  register contents; reg i at [DATA_W*i+DATA_W-1 : DATA_W*i]
we  input  1  write enable of the write path (used only with bypass)
wAddr  input  ADDR_W  write address (used only with bypass)
wData  input  DATA_W  write data (used only with bypass)
rd_valid  output  1  rd_data/rd_addr hold a beat
rd_ready  input  1  consumer accepts the beat
rd_data  output  DATA_W  registered read data
rd_addr  output  ADDR_W  register index of the current beat
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of burst

Behaviour:
- Reset, asynchronous: state=IDLE, rd_valid=0, rd_data=0, rd_addr=0, done=0, busy=0, beat counter=0.
- FSM states: IDLE, READ, DONE.
- IDLE:
  - start=1 and burst_len!=0: next edge -> READ. Load rd_addr=start_addr and rd_data=reg[start_addr]. Set rd_valid=1 and remaining=burst_len-1. Latency is 1 cycle from start to first valid.
  - start=1 and burst_len=0: next edge -> DONE. No beats are issued.
- READ, beat transfer when rd_valid && rd_ready:
  - remaining!=0: on the same edge, load the next beat with addr=rd_addr+1 (mod NREG, 7 wraps to 0) and decrement remaining. rd_valid stays 1, so back-to-back beats run at one per cycle.
  - remaining==0: clear rd_valid and go to DONE.
- Stall: while rd_valid && !rd_ready, rd_data and rd_addr stay stable.
  - Data is captured at load time. Later changes to reg_flat do not alter a held beat.
- DONE: done=1 for exactly this one cycle, busy=1, then IDLE.
- start is ignored while busy. A burst is never restarted or extended mid-flight.
- burst_len > NREG: clamp to NREG, so each register is read at most once per burst.
- reset_n low mid-burst: immediate return to reset values. No done pulse is issued.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined: at every load edge (first or next beat), if we=1 and wAddr equals the address being loaded, rd_data loads wData instead of reg_flat. This gives write-through-same-cycle forwarding.
- Undefined: we, wAddr and wData are ignored, and a same-cycle write returns the old register value. Ports remain present in both builds.

Decomposition:
- Package rf_pkg holds:
  - the state enum {IDLE, READ, DONE}
  - default constants DATA_W=32, ADDR_W=3, NREG
  - the reg_flat slicing helper function
- Sub-module rf_read_mux: combinational NREG:1 word select (reg_flat, sel) -> word. It is instantiated once; the bypass compare sits in the parent.

Test Plan:
- Basic burst: reg[i]=32'h1000_000i, rd_ready=1, start with start_addr=2, burst_len=3.
  - Beats (2,h1000_0002), (3,..03), (4,..04) on consecutive cycles.
  - done pulses the cycle after the 3rd beat.
- Wrap-around: start_addr=6, burst_len=4 -> rd_addr sequence 6,7,0,1; busy high from start+1 through DONE.
- Backpressure: burst_len=2, rd_ready low for 3 cycles on beat 0 while reg[start] changes.
  - rd_data holds the originally captured value.
  - The second beat follows 1 cycle after ready rises.
- Zero length and ignored start: burst_len=0 -> no rd_valid, done after 1 cycle. start pulsed during a burst -> no effect on beat count.
- Bypass (macro on): load of addr 5 coincides with we=1, wAddr=5, wData=32'hDEAD_BEEF.
  - Beat shows hDEAD_BEEF.
  - With the macro off, the old reg[5] is shown.
- Reset mid-burst: reset_n low on beat 2 of 5 -> all outputs 0 immediately, no done. A new start after release runs a full burst.
